ad100_fetch: RTL and testbench
==============================

AD100_FETCH -- requirements
Module: ad100_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter QDEPTH, default 2, instruction queue depth in entries (legal 2..4).
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  fetch request valid.
REQ-007 imem_addr  out  30  word address of request (byte PC >> 2).
REQ-008 imem_gnt  in  1  memory accepts request this cycle (handshake = imem_req & imem_gnt).
REQ-009 imem_rvalid  in  1  read data valid, in order, >=1 cycle after grant.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 redirect  in  1  branch/jump taken; restart fetch.
REQ-012 redirect_pc  in  32  new byte PC; bits [1:0] ignored.
REQ-013 inst_valid  out  1  queue head valid to decode.
REQ-014 inst_ready  in  1  decode consumes head (pop = inst_valid & inst_ready).
REQ-015 inst  out  32  queue head instruction.
REQ-016 inst_pc  out  32  byte PC of queue head, bits [1:0] = 0.

Function
REQ-017 Fetch PC register (fpc) SHALL advance by 4 on each grant, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-018 imem_addr SHALL equal fpc[31:2]; imem_addr and imem_req SHALL be stable while imem_req=1 and imem_gnt=0.
REQ-019 At most one request SHALL be outstanding (granted, rvalid not yet received).
REQ-020 FSM states: REQ (imem_req=1), WAIT (outstanding, keep), DROP (outstanding, discard).
REQ-021 REQ -> WAIT on grant; WAIT -> REQ on rvalid if a queue slot is free after that cycle's push/pop, else WAIT -> HOLD-equivalent REQ with imem_req=0 until a slot frees.
REQ-022 imem_req SHALL be 1 only when queue occupancy minus pop this cycle < QDEPTH and no request is outstanding.
REQ-023 On rvalid in WAIT, {imem_rdata, PC of that request} SHALL be pushed; inst_valid rises the following cycle (registered queue, no bypass).
REQ-024 Redirect SHALL flush all queue entries and set fpc = {redirect_pc[31:2],2'b00} the same edge; inst_valid=0 the next cycle.
REQ-025 Redirect while WAIT, or in the same cycle as a grant, SHALL go to DROP; the next rvalid is discarded, then REQ.
REQ-026 Redirect coincident with rvalid in WAIT SHALL discard that data and go to REQ.
REQ-027 Redirect SHALL take priority over pop and push in the same cycle.
REQ-028 Simultaneous push and pop with queue full SHALL be legal and keep occupancy constant.
REQ-029 Queue SHALL never overflow; rvalid in REQ state (no outstanding) is a protocol error and SHALL be ignored.
REQ-030 inst/inst_pc SHALL be stable while inst_valid=1 and inst_ready=0.

Reset
REQ-031 While rst_n=0: fpc=RESET_PC, state=REQ, queue empty, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-032 imem_req SHALL assert the first clk edge after rst_n deasserts with imem_addr=RESET_PC[31:2].
REQ-033 Reset mid-transaction SHALL abandon any outstanding request; late rvalid after reset is ignored.

Structure
REQ-034 Fetch FSM state encoding and the NOP constant 32'h0000_0013 SHALL live in shared package ad100_pkg.
REQ-035 The queue SHALL be a separate sub-module ad100_fetch_fifo (parameter DEPTH, width 64, push/pop/flush, count).

Verification
REQ-036 Reset release, gnt=1 always, rvalid 1 cycle after grant, ready=1 -> inst_pc sequence 0,4,8,C; first inst_valid 3 cycles after reset release.
REQ-037 inst_ready=0 for 10 cycles -> exactly QDEPTH entries held, imem_req=0, no requests lost; ready=1 resumes in PC order.
REQ-038 Redirect to 32'h0000_0103 while WAIT -> next rvalid dropped, next imem_addr=30'h40, next inst_pc=32'h100.
REQ-039 Redirect coincident with pop and rvalid -> queue empty next cycle, no stale inst delivered.
REQ-040 RESET_PC=32'hFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 rst_n pulsed low while WAIT, then late rvalid -> ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ad100_pkg.sv
// Shared fetch-unit types and constants for the ad100 core.
package ad100_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Queue entry layout: {inst[31:0], pc[31:0]}
  localparam int unsigned QW = 64;

endpackage

// File: rtl/ad100_fetch_fifo.sv
// Small instruction queue: registered head, push/pop/flush, flush wins.
module ad100_fetch_fifo
  import ad100_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [QW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          head_valid,
  output logic [QW-1:0] head_data,
  output logic [2:0]    count
);

  logic [QW-1:0] mem_q [DEPTH];
  logic [QW-1:0] mem_d [DEPTH];
  logic [1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [2:0]    count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    pop_ok  = pop && (count_q != 3'd0);
    // a full queue may still accept a push when the head leaves the same edge
    push_ok = push && ((count_q < 3'(DEPTH)) || pop_ok);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = 2'd0;
      wr_d    = 2'd0;
      count_d = 3'd0;
    end else begin
      if (push_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_q == 2'(i)) mem_d[i] = push_data;
        end
        wr_d = ptr_inc(wr_q);
      end
      if (pop_ok) rd_d = ptr_inc(rd_q);
      count_d = count_q + {2'b00, push_ok} - {2'b00, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= 2'd0;
      wr_q    <= 2'd0;
      count_q <= 3'd0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    head_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((count_q != 3'd0) && (rd_q == 2'(i))) head_data = mem_q[i];
    end
  end

  assign head_valid = (count_q != 3'd0);
  assign count      = count_q;

endmodule

// File: rtl/ad100_fetch.sv
// Instruction fetch: single-outstanding memory requests feeding a small queue.
// state | meaning
// REQ   | no request outstanding; request issued when the queue has room
// WAIT  | one request outstanding, its data will be queued
// DROP  | one request outstanding, its data will be discarded (redirected)
module ad100_fetch
  import ad100_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  fetch_state_e  state_q, state_d;
  logic [29:0]   fpc_q, fpc_d;
  logic [29:0]   req_pc_q, req_pc_d;
  logic          run_q, run_d;
  logic          push, pop;
  logic [2:0]    q_count, occ;
  logic [QW-1:0] head;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign run_d         = 1'b1;

  assign pop = inst_valid && inst_ready && !redirect;
  assign occ = q_count - {2'b00, pop};

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    imem_req = 1'b0;
    push     = 1'b0;
    case (state_q)
      FS_REQ: begin
        // run_q holds requests off until the first edge after reset release
        imem_req = run_q && (occ < 3'(QDEPTH));
        if (imem_req && imem_gnt) begin
          req_pc_d = fpc_q;
          fpc_d    = fpc_q + 30'd1;
          state_d  = redirect ? FS_DROP : FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (redirect) begin
          state_d = imem_rvalid ? FS_REQ : FS_DROP;
        end else if (imem_rvalid) begin
          push    = 1'b1;
          state_d = FS_REQ;
        end
      end
      FS_DROP: begin
        if (imem_rvalid) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
    if (redirect) fpc_d = redirect_pc[31:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FS_REQ;
      fpc_q    <= RESET_PC[31:2];
      req_pc_q <= 30'd0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      run_q    <= run_d;
    end
  end

  ad100_fetch_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({imem_rdata, req_pc_q, 2'b00}),
    .pop       (pop),
    .flush     (redirect),
    .head_valid(inst_valid),
    .head_data (head),
    .count     (q_count)
  );

  assign imem_addr = fpc_q;
  assign inst      = head[63:32];
  assign inst_pc   = head[31:0];

endmodule

// File: tb/tb_ad100_fetch.sv
// Directed bench for ad100_fetch: two instances (default and wrapping RESET_PC).
module tb_ad100_fetch;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;

  logic        gnt_drv, rvalid_drv;
  logic [31:0] rdata_drv;
  logic        sel;
  logic        gnt_en;
  int          lat;
  int          n_grants;

  logic        a_req, a_valid, b_req, b_valid;
  logic [29:0] a_addr, b_addr;
  logic [31:0] a_inst, a_pc, b_inst, b_pc;

  logic        obs_req, obs_valid;
  logic [29:0] obs_addr;
  logic [31:0] obs_inst, obs_pc;

  int          total, bad;
  logic [31:0] cpc [8];
  logic [31:0] cins [8];
  int          ccyc [8];
  int          cgot;

  ad100_fetch u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req(a_req), .imem_addr(a_addr),
    .imem_gnt(gnt_drv & ~sel), .imem_rvalid(rvalid_drv & ~sel), .imem_rdata(rdata_drv),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(a_valid), .inst_ready(inst_ready), .inst(a_inst), .inst_pc(a_pc)
  );

  ad100_fetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_gnt(gnt_drv & sel), .imem_rvalid(rvalid_drv & sel), .imem_rdata(rdata_drv),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(b_valid), .inst_ready(inst_ready), .inst(b_inst), .inst_pc(b_pc)
  );

  assign obs_req   = sel ? b_req   : a_req;
  assign obs_addr  = sel ? b_addr  : a_addr;
  assign obs_valid = sel ? b_valid : a_valid;
  assign obs_inst  = sel ? b_inst  : a_inst;
  assign obs_pc    = sel ? b_pc    : a_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h5A00_0013;
  endfunction

  // Memory model: drives at negedge+1, samples the handshake at negedge+4.
  initial begin : responder
    logic        have_out;
    logic [29:0] out_addr;
    int          out_dly;
    have_out   = 1'b0;
    out_addr   = '0;
    out_dly    = 0;
    gnt_drv    = 1'b0;
    rvalid_drv = 1'b0;
    rdata_drv  = '0;
    n_grants   = 0;
    forever begin
      @(negedge clk);
      #1;
      rvalid_drv = 1'b0;
      if (have_out) begin
        if (out_dly == 0) begin
          rvalid_drv = 1'b1;
          rdata_drv  = mem_word(out_addr);
          have_out   = 1'b0;
        end else begin
          out_dly = out_dly - 1;
        end
      end
      gnt_drv = gnt_en;
      #3;
      if (obs_req && gnt_drv) begin
        have_out = 1'b1;
        out_addr = obs_addr;
        out_dly  = lat - 1;
        n_grants = n_grants + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (5) tick();
    rst_n = 1'b1;
    #3;
  endtask

  // Records pops starting at the current sample point (negedge+3).
  task automatic collect(input int want, input int budget);
    cgot = 0;
    for (int c = 0; c < budget && cgot < want; c++) begin
      if (obs_valid && inst_ready) begin
        cpc[cgot]  = obs_pc;
        cins[cgot] = obs_inst;
        ccyc[cgot] = c;
        cgot++;
      end
      tick();
      #3;
    end
  endtask

  task automatic test_reset_stream();
    sel = 1'b0; gnt_en = 1'b1; lat = 1; inst_ready = 1'b1;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    #3;
    total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %0b want 0", obs_req); end
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", obs_valid); end
    total++; if (obs_inst !== 32'h0) begin bad++; $display("FAIL rst_inst: got %h want 0", obs_inst); end
    total++; if (obs_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", obs_pc); end
    tick();
    rst_n = 1'b1;
    #3;
    tick();
    #3;
    total++; if (obs_req !== 1'b1) begin bad++; $display("FAIL first_req: got %0b want 1", obs_req); end
    total++; if (obs_addr !== 30'h0) begin bad++; $display("FAIL first_addr: got %h want 0", obs_addr); end
    collect(4, 20);
    total++; if (cgot != 4) begin bad++; $display("FAIL stream_count: got %0d want 4", cgot); end
    // collection starts one cycle after release, so index 2 is the third cycle
    total++; if (ccyc[0] != 2) begin bad++; $display("FAIL first_valid_cycle: got %0d want 2", ccyc[0]); end
    for (int i = 0; i < cgot; i++) begin
      total++; if (cpc[i] !== 32'(i * 4)) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, cpc[i], 32'(i * 4)); end
      total++; if (cins[i] !== mem_word(30'(i))) begin bad++; $display("FAIL stream_inst[%0d]: got %h want %h", i, cins[i], mem_word(30'(i))); end
    end
  endtask

  task automatic test_gnt_stall();
    sel = 1'b0; gnt_en = 1'b0; lat = 1; inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      #3;
      total++; if (obs_req !== 1'b1) begin bad++; $display("FAIL stall_req[%0d]: got %0b want 1", c, obs_req); end
      total++; if (obs_addr !== 30'h0) begin bad++; $display("FAIL stall_addr[%0d]: got %h want 0", c, obs_addr); end
    end
    gnt_en = 1'b1;
    collect(1, 20);
    total++; if (cgot != 1 || cpc[0] !== 32'h0) begin bad++; $display("FAIL stall_pop: got n=%0d pc=%h want n=1 pc=0", cgot, cpc[0]); end
  endtask

  task automatic test_backpressure();
    int g0;
    sel = 1'b0; gnt_en = 1'b1; lat = 1; inst_ready = 1'b0;
    do_reset();
    g0 = n_grants;
    repeat (10) tick();
    #3;
    total++; if (n_grants - g0 != 2) begin bad++; $display("FAIL bp_grants: got %0d want 2", n_grants - g0); end
    total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL bp_req: got %0b want 0", obs_req); end
    total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %0b want 1", obs_valid); end
    total++; if (obs_pc !== 32'h0) begin bad++; $display("FAIL bp_head: got %h want 0", obs_pc); end
    inst_ready = 1'b1;
    collect(3, 20);
    total++; if (cgot != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", cgot); end
    for (int i = 0; i < cgot; i++) begin
      total++; if (cpc[i] !== 32'(i * 4)) begin bad++; $display("FAIL bp_pc[%0d]: got %h want %h", i, cpc[i], 32'(i * 4)); end
    end
    total++; if (ccyc[1] != ccyc[0] + 1) begin bad++; $display("FAIL bp_b2b: got %0d want %0d", ccyc[1], ccyc[0] + 1); end
  endtask

  task automatic test_redirect_wait();
    logic found;
    sel = 1'b0; gnt_en = 1'b1; lat = 3; inst_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      #3;
      if (obs_req && gnt_drv) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rw_grant: got %0b want 1", found); end
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    #3;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (obs_req) begin
        found = 1'b1;
        total++; if (obs_addr !== 30'h40) begin bad++; $display("FAIL rw_addr: got %h want 40", obs_addr); end
      end else begin
        tick();
        #3;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rw_req_timeout: got %0b want 1", found); end
    collect(1, 20);
    total++; if (cgot != 1 || cpc[0] !== 32'h100) begin bad++; $display("FAIL rw_pc: got n=%0d pc=%h want n=1 pc=100", cgot, cpc[0]); end
    total++; if (cins[0] !== mem_word(30'h40)) begin bad++; $display("FAIL rw_inst: got %h want %h", cins[0], mem_word(30'h40)); end
  endtask

  task automatic test_redirect_pop_rvalid();
    int   g0;
    logic found;
    sel = 1'b0; gnt_en = 1'b1; lat = 1; inst_ready = 1'b0;
    do_reset();
    g0 = n_grants;
    for (int c = 0; c < 20 && (n_grants - g0 != 2); c++) begin
      tick();
      #3;
    end
    // second response is on the bus now, head holds pc 0
    redirect = 1'b1; redirect_pc = 32'h0000_0200; inst_ready = 1'b1;
    total++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin bad++; $display("FAIL rpr_setup: got v=%0b pc=%h want v=1 pc=0", obs_valid, obs_pc); end
    total++; if (rvalid_drv !== 1'b1) begin bad++; $display("FAIL rpr_rvalid_align: got %0b want 1", rvalid_drv); end
    tick();
    redirect = 1'b0;
    #3;
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL rpr_flush: got %0b want 0", obs_valid); end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (obs_req) begin
        found = 1'b1;
        total++; if (obs_addr !== 30'h80) begin bad++; $display("FAIL rpr_addr: got %h want 80", obs_addr); end
      end else begin
        tick();
        #3;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rpr_req_timeout: got %0b want 1", found); end
    collect(1, 20);
    total++; if (cgot != 1 || cpc[0] !== 32'h200) begin bad++; $display("FAIL rpr_pc: got n=%0d pc=%h want n=1 pc=200", cgot, cpc[0]); end
    total++; if (cins[0] !== mem_word(30'h80)) begin bad++; $display("FAIL rpr_inst: got %h want %h", cins[0], mem_word(30'h80)); end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    sel = 1'b1; gnt_en = 1'b1; lat = 1; inst_ready = 1'b1;
    do_reset();
    collect(3, 30);
    total++; if (cgot != 3) begin bad++; $display("FAIL wrap_count: got %0d want 3", cgot); end
    for (int i = 0; i < cgot; i++) begin
      total++; if (cpc[i] !== wexp[i]) begin bad++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, cpc[i], wexp[i]); end
      total++; if (cins[i] !== mem_word(wexp[i][31:2])) begin bad++; $display("FAIL wrap_inst[%0d]: got %h want %h", i, cins[i], mem_word(wexp[i][31:2])); end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic found;
    sel = 1'b0; gnt_en = 1'b1; lat = 3; inst_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      #3;
      if (obs_req && gnt_drv && obs_addr == 30'd1) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rm_grant: got %0b want 1", found); end
    tick();
    rst_n = 1'b0;
    #3;
    total++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin bad++; $display("FAIL rm_in_reset: got req=%0b v=%0b want 0 0", obs_req, obs_valid); end
    tick();
    rst_n = 1'b1;
    #3;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (obs_req) begin
        found = 1'b1;
        total++; if (obs_addr !== 30'h0) begin bad++; $display("FAIL rm_addr: got %h want 0", obs_addr); end
      end else begin
        tick();
        #3;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rm_req_timeout: got %0b want 1", found); end
    collect(2, 30);
    total++; if (cgot != 2) begin bad++; $display("FAIL rm_count: got %0d want 2", cgot); end
    for (int i = 0; i < cgot; i++) begin
      total++; if (cpc[i] !== 32'(i * 4)) begin bad++; $display("FAIL rm_pc[%0d]: got %h want %h", i, cpc[i], 32'(i * 4)); end
      total++; if (cins[i] !== mem_word(30'(i))) begin bad++; $display("FAIL rm_inst[%0d]: got %h want %h", i, cins[i], mem_word(30'(i))); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    sel = 1'b0; gnt_en = 1'b0; lat = 1;
    test_reset_stream();
    test_gnt_stall();
    test_backpressure();
    test_redirect_wait();
    test_redirect_pop_rvalid();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
